// File: rtl/seq_det_pkg.sv
// Shared types and reset configuration for the programmable serial pattern detector.
package seq_det_pkg;

   localparam int SEQ_MAX_LEN = 8;
   localparam int SEQ_LEN_W   = $clog2(SEQ_MAX_LEN + 1);

   typedef struct packed {
      logic [SEQ_MAX_LEN-1:0] pattern;
      logic [SEQ_LEN_W-1:0]   len;
      logic                   overlap;
   } seq_cfg_t;

   localparam seq_cfg_t SEQ_DEF_CFG = '{pattern: 8'b0000_1101, len: 4'd4, overlap: 1'b0};

   // Length 0 behaves as 1; anything above the history depth saturates.
   function automatic int clamp_len(input int len, input int max_len);
      if (len == 0)       return 1;
      if (len > max_len)  return max_len;
      return len;
   endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter; a clear coinciding with an increment leaves 1 so the event is kept.
module seq_det_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? CNT_W'(1) : '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable Mealy bit-pattern detector with overlap mode, valid qualifier and
// saturating match counter.
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = SEQ_MAX_LEN,
   parameter int                 CNT_W       = 16,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_CFG.pattern),
   parameter int                 DEF_LEN     = int'(SEQ_DEF_CFG.len),
   parameter logic               DEF_OVERLAP = SEQ_DEF_CFG.overlap
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         in,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clr,
   output logic                         out,
   output logic                         out_q,
   output logic [CNT_W-1:0]             match_cnt
);

   localparam int LW = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               ovl;
   logic [MAX_LEN-2:0] hist;
   logic [LW-1:0]      fill;

   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] mask;
   logic               fill_ok;
   logic               hit;

   // Candidate window: history with the incoming bit appended as bit 0.
   assign cand = {hist, in};

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
   end

   assign fill_ok = (fill >= (len - LW'(1)));
   assign hit     = (((cand ^ pat) & mask) == '0);
   assign out     = reset & in_valid & ~cfg_load & fill_ok & hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat   <= DEF_PATTERN;
         len   <= LW'(DEF_LEN);
         ovl   <= DEF_OVERLAP;
         hist  <= '0;
         fill  <= '0;
         out_q <= 1'b0;
      end else begin
         out_q <= out;
         if (cfg_load) begin
            pat  <= cfg_pattern;
            len  <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
         end else if (in_valid) begin
            hist <= cand[MAX_LEN-2:0];
            // Non-overlapping: a match consumes its bits, so the next one needs a fresh window.
            if (out && !ovl)   fill <= '0;
            else if (!fill_ok) fill <= fill + LW'(1);
         end
      end
   end

   seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out),
      .clr   (cnt_clr | cfg_load),
      .cnt   (match_cnt)
   );

endmodule
